keypad_scanner: RTL and testbench

Input-side counterpart of the multiplexed 7-segment display path. The display path drives digit selects in rotation and pushes segment data out. This block drives 4x4 keypad columns in rotation and reads row lines back in. It debounces the matrix and delivers one validated 4-bit key index per press to the stopwatch/control logic, for example as a digit-entry or start/stop source.

---
 rtl/keypad_pkg.sv | 17 +
 rtl/keypad_col_scan.sv | 34 +++
 rtl/keypad_scanner.sv | 119 +++++++++++
 tb/tb_keypad_scanner.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants, FSM state type and scan-summary helpers for keypad_scanner
package keypad_pkg;
  localparam int NCOL = 4;
  localparam int NROW = 4;
  localparam int KEY_W = 4;
  localparam int NKEY = NCOL * NROW;
  localparam int COL_W = $clog2(NCOL);
  localparam int ROW_W = $clog2(NROW);
  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
  function automatic logic single_key(input logic [NKEY-1:0] m);
    return m != '0 && (m & (m - NKEY'(1))) == '0;
  endfunction
  function automatic logic [KEY_W-1:0] key_index(input logic [NKEY-1:0] m);
    key_index = '0;
    for (int i = 0; i < NKEY; i++) if (m[i]) key_index = KEY_W'(i);
  endfunction
endpackage

// File: rtl/keypad_col_scan.sv
// keypad_col_scan: column rotation, row synchronizer and per-slot / end-of-scan sample strobes
module keypad_col_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NROW-1:0]  row,
  output logic [NCOL-1:0]  col,
  output logic [COL_W-1:0] col_idx,
  output logic [NROW-1:0]  row_s,
  output logic             sample,
  output logic             eos
);
  localparam int DW = $clog2(SCAN_DIV);
  logic [DW-1:0] div;
  logic [NROW-1:0] row_m;
  assign sample = div == DW'(SCAN_DIV - 1);
  assign eos = sample && col_idx == COL_W'(NCOL - 1);
  assign col = ~(NCOL'(1) << col_idx);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      div <= '0;
      col_idx <= '0;
      row_m <= '1;
      row_s <= '1;
    end else begin
      row_m <= row;
      row_s <= row_m;
      div <= sample ? '0 : div + 1'b1;
      if (sample) col_idx <= col_idx + 1'b1;
    end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: debounced 4x4 keypad scanner, one key_valid per press; define TYPEMATIC_EN for auto-repeat
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY_SCANS = 50,
  parameter int REPEAT_RATE_SCANS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NROW-1:0]  row,
  output logic [NCOL-1:0]  col,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held
);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_SCANS);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [KEY_W-1:0] cand, cand_n, idx;
  logic [COL_W-1:0] col_idx;
  logic [NROW-1:0] row_s;
  logic [NKEY-1:0] seen, full;
  logic sample, eos, single, cand_seen, accept, rep;

  keypad_col_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk(clk),
    .reset(reset),
    .row(row),
    .col(col),
    .col_idx(col_idx),
    .row_s(row_s),
    .sample(sample),
    .eos(eos)
  );

  // full = pressed map of this scan, with the slot being sampled right now merged in
  always_comb begin
    full = seen;
    for (int r = 0; r < NROW; r++) full[{ROW_W'(r), col_idx}] = ~row_s[r];
  end

  assign single = single_key(full);
  assign idx = key_index(full);
  assign cand_seen = full[cand];
  assign cnt_inc = cnt == DB_MAX ? cnt : cnt + 1'b1;
  assign key_held = state == PRESSED || state == RELEASE;

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    cand_n = cand;
    accept = 1'b0;
    if (eos)
      case (state)
        IDLE: if (single) begin
          cand_n = idx;
          cnt_n = CW'(1);
          accept = DEBOUNCE_SCANS == 1;
          state_n = accept ? PRESSED : DEBOUNCE;
        end
        DEBOUNCE: if (single && idx == cand) begin
          cnt_n = cnt_inc;
          accept = cnt_inc == DB_MAX;
          state_n = accept ? PRESSED : DEBOUNCE;
        end else state_n = IDLE;
        PRESSED: if (!cand_seen) begin
          cnt_n = CW'(1);
          state_n = DEBOUNCE_SCANS == 1 ? IDLE : RELEASE;
        end
        RELEASE: if (cand_seen) state_n = PRESSED;
        else begin
          cnt_n = cnt_inc;
          state_n = cnt_inc == DB_MAX ? IDLE : RELEASE;
        end
        default: state_n = IDLE;
      endcase
  end

`ifdef TYPEMATIC_EN
  localparam int RMAX = REPEAT_DELAY_SCANS > REPEAT_RATE_SCANS ? REPEAT_DELAY_SCANS : REPEAT_RATE_SCANS;
  localparam int RW = $clog2(RMAX + 1);
  logic [RW-1:0] rcnt, rcnt_n;
  // countdown to the next repeat; frozen outside PRESSED scans
  always_comb begin
    rep = 1'b0;
    rcnt_n = rcnt;
    if (accept) rcnt_n = RW'(REPEAT_DELAY_SCANS);
    else if (eos && state == PRESSED && cand_seen && rcnt != '0) begin
      rep = rcnt == RW'(1);
      rcnt_n = rep ? RW'(REPEAT_RATE_SCANS) : rcnt - 1'b1;
    end else if (state_n == IDLE) rcnt_n = '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) rcnt <= '0;
    else rcnt <= rcnt_n;
`else
  assign rep = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      cand <= '0;
      seen <= '0;
      key_code <= '0;
      key_valid <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      cand <= cand_n;
      if (sample) seen <= full;
      if (accept) key_code <= cand_n;
      key_valid <= accept || rep;
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized and directed keypad presses checked against a per-scan behavioural model
module tb_keypad_scanner;
  localparam int SD = 8, DB = 3, RD = 4, RR = 2, SCAN = 4 * SD;
  logic clk = 1'b0, reset = 1'b0;
  logic [3:0] row, col, key_code;
  logic key_valid, key_held;
  logic [15:0] cur_mask = '0;
  int checks = 0, errors = 0, edges = 0, scan_no = 0, vcount = 0, last_pulse = 0;
  bit held = 0, exp_valid = 0;
  logic [3:0] code = '0;
  int run_len = 0, run_key = 0, miss = 0, since = 0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB), .REPEAT_DELAY_SCANS(RD), .REPEAT_RATE_SCANS(RR)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && cur_mask[r*4+c]) row[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // one full scan of the keypad, judged from the set of pressed keys only
  task automatic model_scan(input logic [15:0] m);
    int n, k;
    n = $countones(m);
    k = 0;
    for (int i = 15; i >= 0; i--) if (m[i]) k = i;
    scan_no++;
    if (!held) begin
      if (run_len > 0 && !(n == 1 && k == run_key)) run_len = 0;
      else if (n == 1) begin
        run_key = k;
        run_len++;
        if (run_len >= DB) begin
          held = 1; code = 4'(k); exp_valid = 1; run_len = 0; miss = 0; since = 0;
        end
      end
    end else if (m[code]) begin
      if (miss == 0) begin
        since++;
`ifdef TYPEMATIC_EN
        if (since == RD || (since > RD && (since - RD) % RR == 0)) exp_valid = 1;
`endif
      end
      miss = 0;
    end else begin
      miss++;
      if (miss >= DB) begin held = 0; run_len = 0; end
    end
  endtask

  initial forever begin
    logic [3:0] ec;
    @(negedge clk);
    if (!reset) begin
      held = 0; exp_valid = 0; code = '0; run_len = 0; miss = 0; since = 0; edges = 0;
    end else begin
      edges++;
      exp_valid = 0;
      if (edges % SCAN == 0) model_scan(cur_mask);
    end
    if (key_valid === 1'b1) begin vcount++; last_pulse = scan_no; end
    ec = ~(4'b0001 << ((edges / SD) % 4));
    chk("col", 32'(col), 32'(ec));
    chk("key_valid", 32'(key_valid), 32'(exp_valid));
    chk("key_held", 32'(key_held), 32'(held));
    chk("key_code", 32'(key_code), 32'(code));
  end

  task automatic scan(input logic [15:0] m);
    cur_mask = m;
    repeat (SCAN) @(negedge clk);
    #1;
  endtask

  initial begin
    int v0, s0, k, len, kind;
    logic [15:0] m;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_col", 32'(col), 32'(4'b1110));
    chk("reset_held", 32'(key_held), 0);
    #1 reset = 1'b1;
    // key 9 = row2/col1
    v0 = vcount; s0 = scan_no;
    repeat (5) scan(16'(1) << 9);
    chk("t2_pulses", 32'(vcount - v0), 1);
    chk("t2_latency", 32'(last_pulse - s0), 3);
    chk("t2_code", 32'(key_code), 9);
    chk("t2_model_code", 32'(code), 9);
    chk("t2_held", 32'(key_held), 1);
    repeat (2) scan('0);
    chk("t2_held_2empty", 32'(key_held), 1);
    scan('0);
    chk("t2_released", 32'(key_held), 0);
    // bounce
    v0 = vcount; s0 = scan_no;
    scan(16'(1) << 6); scan(16'(1) << 6); scan('0);
    scan(16'(1) << 6); scan(16'(1) << 6); scan(16'(1) << 6);
    chk("t3_pulses", 32'(vcount - v0), 1);
    chk("t3_scan", 32'(last_pulse - s0), 6);
    repeat (3) scan('0);
    // two keys from idle
    v0 = vcount;
    repeat (10) scan(16'h0021);
    chk("t4_pulses", 32'(vcount - v0), 0);
    chk("t4_held", 32'(key_held), 0);
    scan('0);
    // re-press during release
    v0 = vcount;
    repeat (3) scan(16'(1) << 12);
    chk("t5_held_a", 32'(key_held), 1);
    scan('0);
    chk("t5_held_b", 32'(key_held), 1);
    for (int i = 0; i < 3; i++) begin
      scan(16'(1) << 12);
      chk("t5_held_c", 32'(key_held), 1);
    end
    chk("t5_pulses", 32'(vcount - v0), 1);
    chk("t5_code", 32'(key_code), 12);
    repeat (3) scan('0);
    // typematic
    v0 = vcount;
    repeat (15) scan(16'(1) << 3);
`ifdef TYPEMATIC_EN
    chk("t6_pulses", 32'(vcount - v0), 6);
`else
    chk("t6_pulses", 32'(vcount - v0), 1);
`endif
    repeat (3) scan('0);
    // reset mid-slot while a key is held
    repeat (3) scan(16'(1) << 9);
    repeat (11) @(negedge clk);
    #3 reset = 1'b0;
    #1;
    chk("t1_col", 32'(col), 32'(4'b1110));
    chk("t1_code", 32'(key_code), 0);
    chk("t1_valid", 32'(key_valid), 0);
    chk("t1_held", 32'(key_held), 0);
    cur_mask = '0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(15);
      len = $urandom_range(1, 7);
      kind = $urandom_range(9);
      for (int j = 0; j < len; j++) begin
        m = 16'(1) << k;
        if (kind == 0) m = m | (16'(1) << $urandom_range(15));
        else if (kind == 1 && $urandom_range(3) == 0) m = '0;
        else if (kind == 2 && j >= 2) m = m | (16'(1) << $urandom_range(15));
        scan(m);
      end
      repeat ($urandom_range(0, 4)) scan('0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
